fifo_ctrl: RTL and testbench

- Pointer and occupancy controller for the FIFO datapath.
- Sits directly upstream of the dual-address storage RAM (DATA_BITS x 2^ADDR_BITS, 1-cycle registered read). Drives that RAM's write, read, addr_write and addr_read, and forwards push data to it.
- Produces full, empty, almost-full and almost-empty flags, a read-data-valid strobe aligned to the RAM's registered output, and a sticky error flag for overflow/underflow.

---
 rtl/fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_fifo_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller for a FIFO built on a 1-cycle registered-read RAM.
// Ports: clk, reset (async, active-high); push/pop/data_in requests; umbral_alto/umbral_bajo
//        thresholds latched in INIT; ram_* drive the RAM; valid_out tags RAM data_out;
//        count/full/empty/almost_full/almost_empty occupancy flags; error is sticky.
module fifo_ctrl #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic [ADDR_BITS:0]   umbral_alto,
    input  logic [ADDR_BITS:0]   umbral_bajo,
    output logic [DATA_BITS-1:0] ram_data_in,
    output logic                 ram_write,
    output logic                 ram_read,
    output logic [ADDR_BITS-1:0] ram_addr_write,
    output logic [ADDR_BITS-1:0] ram_addr_read,
    output logic                 valid_out,
    output logic [ADDR_BITS:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    localparam logic [ADDR_BITS:0]   DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0]   CNT_ONE = 1;
    localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   cnt;
    logic [ADDR_BITS:0]   thr_hi;
    logic [ADDR_BITS:0]   thr_lo;
    logic                 valid_q;

    logic active;
    logic is_full;
    logic is_empty;
    logic push_ok;
    logic pop_ok;
    logic ovf;
    logic udf;

    assign active   = (state == S_ACTIVE);
    assign is_full  = (cnt == DEPTH);
    assign is_empty = (cnt == '0);

    // A pop frees a slot on the same edge, so a full FIFO still takes a push
    // when the pop alongside it is accepted.
    assign pop_ok  = active & pop & ~is_empty;
    assign push_ok = active & push & (~is_full | pop_ok);
    assign ovf     = active & push & is_full & ~pop;
    assign udf     = active & pop & is_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT:   state_nxt = S_ACTIVE;
            S_ACTIVE: if (ovf | udf) state_nxt = S_ERROR;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        ram_write    = 1'b0;
        ram_read     = 1'b0;
        error        = 1'b0;
        full         = is_full;
        empty        = is_empty;
        // Thresholds are still zero during INIT; hold the reset flag values.
        almost_full  = (state != S_INIT) && (cnt >= thr_hi);
        almost_empty = (state == S_INIT) || (cnt <= thr_lo);
        unique case (state)
            S_ACTIVE: begin
                ram_write = push_ok;
                ram_read  = pop_ok;
            end
            S_ERROR:  error = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            thr_hi  <= '0;
            thr_lo  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            if (state == S_INIT) begin
                thr_hi <= umbral_alto;
                thr_lo <= umbral_bajo;
            end
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    assign ram_data_in    = data_in;
    assign ram_addr_write = wr_ptr;
    assign ram_addr_read  = rd_ptr;
    assign valid_out      = valid_q;
    assign count          = cnt;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: vector table plus scoreboard bench for fifo_ctrl
// with a behavioural registered-read RAM attached to its ram_* ports.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] data_in;
    logic [3:0] umbral_alto;
    logic [3:0] umbral_bajo;
    logic [9:0] ram_data_in;
    logic       ram_write;
    logic       ram_read;
    logic [2:0] ram_addr_write;
    logic [2:0] ram_addr_read;
    logic       valid_out;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;

    logic [9:0] mem [8];
    logic [9:0] rdata;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb [$];

    typedef struct {
        logic [1:0] po;
        logic [9:0] d;
        logic [1:0] wr;
        logic [3:0] cnt;
        logic [3:0] flg;
    } vec_t;

    vec_t vec [16];

    fifo_ctrl #(.DATA_BITS(10), .ADDR_BITS(3)) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .data_in(data_in),
        .umbral_alto(umbral_alto),
        .umbral_bajo(umbral_bajo),
        .ram_data_in(ram_data_in),
        .ram_write(ram_write),
        .ram_read(ram_read),
        .ram_addr_write(ram_addr_write),
        .ram_addr_read(ram_addr_read),
        .valid_out(valid_out),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr_write] <= ram_data_in;
        if (ram_read)  rdata <= mem[ram_addr_read];
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // flg = {full, empty, almost_full, almost_empty}
    task automatic chk_st(input logic [3:0] c, input logic [3:0] flg, input logic e);
        chk("count", 32'(count), 32'(c));
        chk("flags", 32'({full, empty, almost_full, almost_empty}), 32'(flg));
        chk("error", 32'(error), 32'(e));
    endtask

    // Drive one cycle of requests; wr = expected {ram_write, ram_read}.
    task automatic step(input logic [1:0] po, input logic [9:0] d, input logic [1:0] wr);
        logic [9:0] exp_d;
        push    = po[1];
        pop     = po[0];
        data_in = d;
        #1;
        chk("ram_wr_rd", 32'({ram_write, ram_read}), 32'(wr));
        chk("ram_data_in", 32'(ram_data_in), 32'(d));
        if (wr[1]) sb.push_back(d);
        @(posedge clk);
        #1;
        chk("valid_out", 32'(valid_out), 32'(wr[0]));
        if (valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underrun: got valid data %0h expected none", rdata);
            end else begin
                exp_d = sb.pop_front();
                chk("rdata", 32'(rdata), 32'(exp_d));
            end
        end
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        #1;
        chk_st(4'd0, 4'b0101, 1'b0);
        chk("valid_rst", 32'(valid_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_st(4'd0, 4'b0101, 1'b0);
    endtask

    initial begin
        vec[0]  = '{2'b10, 10'h001, 2'b10, 4'd1, 4'b0001};
        vec[1]  = '{2'b10, 10'h002, 2'b10, 4'd2, 4'b0001};
        vec[2]  = '{2'b10, 10'h003, 2'b10, 4'd3, 4'b0000};
        vec[3]  = '{2'b10, 10'h004, 2'b10, 4'd4, 4'b0000};
        vec[4]  = '{2'b10, 10'h005, 2'b10, 4'd5, 4'b0000};
        vec[5]  = '{2'b10, 10'h006, 2'b10, 4'd6, 4'b0010};
        vec[6]  = '{2'b10, 10'h007, 2'b10, 4'd7, 4'b0010};
        vec[7]  = '{2'b10, 10'h008, 2'b10, 4'd8, 4'b1010};
        vec[8]  = '{2'b01, 10'h000, 2'b01, 4'd7, 4'b0010};
        vec[9]  = '{2'b01, 10'h000, 2'b01, 4'd6, 4'b0010};
        vec[10] = '{2'b01, 10'h000, 2'b01, 4'd5, 4'b0000};
        vec[11] = '{2'b01, 10'h000, 2'b01, 4'd4, 4'b0000};
        vec[12] = '{2'b01, 10'h000, 2'b01, 4'd3, 4'b0000};
        vec[13] = '{2'b01, 10'h000, 2'b01, 4'd2, 4'b0001};
        vec[14] = '{2'b01, 10'h000, 2'b01, 4'd1, 4'b0001};
        vec[15] = '{2'b01, 10'h000, 2'b01, 4'd0, 4'b0101};

        push        = 1'b0;
        pop         = 1'b0;
        data_in     = '0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        reset       = 1'b0;

        // Reset, INIT swallows a push, then idle.
        do_reset();
        step(2'b10, 10'h3AA, 2'b00);
        chk_st(4'd0, 4'b0101, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(2'b00, 10'h000, 2'b00);
            chk_st(4'd0, 4'b0101, 1'b0);
        end

        // Fill and drain from the table.
        for (int i = 0; i < 16; i++) begin
            step(vec[i].po, vec[i].d, vec[i].wr);
            chk_st(vec[i].cnt, vec[i].flg, 1'b0);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("wptr_t2", 32'(ram_addr_write), 32'd0);
        chk("rptr_t2", 32'(ram_addr_read), 32'd0);

        // Full, then simultaneous push+pop.
        for (int i = 1; i <= 8; i++) step(2'b10, 10'(i), 2'b10);
        chk_st(4'd8, 4'b1010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 10'h100 + 10'(i), 2'b11);
            chk_st(4'd8, 4'b1010, 1'b0);
        end
        chk("wptr_wrap", 32'(ram_addr_write), 32'd4);
        chk("rptr_wrap", 32'(ram_addr_read), 32'd4);
        for (int i = 0; i < 8; i++) step(2'b01, 10'h000, 2'b01);
        chk_st(4'd0, 4'b0101, 1'b0);
        chk("sb_t3", 32'(sb.size()), 32'd0);
        chk("rptr_t3", 32'(ram_addr_read), 32'd4);

        // Overflow: ninth push is dropped and the state freezes.
        for (int i = 0; i < 8; i++) step(2'b10, 10'h200 + 10'(i), 2'b10);
        step(2'b10, 10'h1FF, 2'b00);
        chk_st(4'd8, 4'b1010, 1'b1);
        step(2'b11, 10'h0F0, 2'b00);
        step(2'b01, 10'h000, 2'b00);
        step(2'b10, 10'h0F1, 2'b00);
        chk_st(4'd8, 4'b1010, 1'b1);
        chk("wptr_frz", 32'(ram_addr_write), 32'd4);
        chk("rptr_frz", 32'(ram_addr_read), 32'd4);

        // Underflow with a concurrent push.
        do_reset();
        step(2'b00, 10'h000, 2'b00);
        step(2'b11, 10'h055, 2'b10);
        chk_st(4'd1, 4'b0001, 1'b1);
        do_reset();
        step(2'b00, 10'h000, 2'b00);
        step(2'b10, 10'h0AA, 2'b10);
        chk_st(4'd1, 4'b0001, 1'b0);
        step(2'b01, 10'h000, 2'b01);
        chk_st(4'd0, 4'b0101, 1'b0);
        chk("sb_t5", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a pop stream.
        for (int i = 0; i < 7; i++) step(2'b10, 10'h300 + 10'(i), 2'b10);
        step(2'b01, 10'h000, 2'b01);
        step(2'b01, 10'h000, 2'b01);
        chk_st(4'd5, 4'b0000, 1'b0);
        pop   = 1'b1;
        reset = 1'b1;
        #1;
        chk_st(4'd0, 4'b0101, 1'b0);
        chk("valid_async", 32'(valid_out), 32'd0);
        chk("ram_rd_async", 32'(ram_read), 32'd0);
        pop = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        step(2'b00, 10'h000, 2'b00);
        step(2'b10, 10'h011, 2'b10);
        step(2'b01, 10'h000, 2'b01);
        chk_st(4'd0, 4'b0101, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
